// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF race logic.
// Holds the race FSM states, the per-pair decision kinds and a width helper.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_STORE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        D_A_WIN,
        D_B_WIN,
        D_TIE,
        D_TMO
    } decision_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/ro_sat_counter.sv
// Saturating edge counter for one oscillator of a raced pair.
// Stops at all-ones or when frozen by the opposing counter saturating.
module ro_sat_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == '1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !freeze && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ro_race_arbiter.sv
// Ring-oscillator PUF response generator: races each pair in turn until a
// counter saturates or the timeout expires, recording one bit and a margin.
module ro_race_arbiter
    import ro_puf_pkg::*;
#(
    parameter int unsigned       CNT_W   = 8,
    parameter int unsigned       N_PAIRS = 4,
    parameter int unsigned       TMO_W   = 16,
    parameter logic [TMO_W-1:0]  TIMEOUT = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N_PAIRS-1:0]            edge_a,
    input  logic [N_PAIRS-1:0]            edge_b,
    output logic                          busy,
    output logic                          done,
    output logic [N_PAIRS-1:0]            response,
    output logic                          pair_valid,
    output logic [clog2(N_PAIRS)-1:0]     pair_idx,
    output logic [CNT_W-1:0]              margin,
    output logic                          tie_flag,
    output logic                          tmo_flag
);

    localparam int unsigned      IDX_W    = clog2(N_PAIRS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIRS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - TMO_W'(1);

    state_t           state_q, state_d;
    decision_t        dec_q, dec_d;
    logic [TMO_W-1:0] timer;
    logic [CNT_W-1:0] cnt_a, cnt_b, margin_q, store_margin;
    logic             at_max_a, at_max_b, store_bit;
    logic             counting, clearing;

    assign counting = (state_q == S_COUNT);
    assign clearing = (state_q == S_CLEAR);

    ro_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (clearing),
        .inc    (counting && edge_a[pair_idx]),
        .freeze (at_max_a || at_max_b),
        .cnt    (cnt_a),
        .at_max (at_max_a)
    );

    ro_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (clearing),
        .inc    (counting && edge_b[pair_idx]),
        .freeze (at_max_a || at_max_b),
        .cnt    (cnt_b),
        .at_max (at_max_b)
    );

    // Exit priority: tie, A, B, then timeout; saturation beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_COUNT;
            S_COUNT: begin
                if (at_max_a && at_max_b) begin
                    state_d = S_STORE;
                    dec_d   = D_TIE;
                end else if (at_max_a) begin
                    state_d = S_STORE;
                    dec_d   = D_A_WIN;
                end else if (at_max_b) begin
                    state_d = S_STORE;
                    dec_d   = D_B_WIN;
                end else if (timer == TMO_LAST) begin
                    state_d = S_STORE;
                    dec_d   = D_TMO;
                end
            end
            S_STORE: state_d = (pair_idx == LAST_IDX) ? S_DONE : S_CLEAR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        store_bit    = 1'b0;
        store_margin = '0;
        case (dec_q)
            D_A_WIN: begin
                store_bit    = 1'b1;
                store_margin = cnt_b;
            end
            D_B_WIN: store_margin = cnt_a;
            D_TIE:   store_margin = '1;
            D_TMO:   store_bit    = (cnt_a > cnt_b);
            default: store_bit    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dec_q    <= D_A_WIN;
            timer    <= '0;
            pair_idx <= '0;
            response <= '0;
            margin_q <= '0;
            tie_flag <= 1'b0;
            tmo_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        response <= '0;
                        tie_flag <= 1'b0;
                        tmo_flag <= 1'b0;
                        pair_idx <= '0;
                    end
                end
                S_CLEAR: timer <= '0;
                S_COUNT: begin
                    timer <= timer + TMO_W'(1);
                    dec_q <= dec_d;
                end
                S_STORE: begin
                    response[pair_idx] <= store_bit;
                    margin_q           <= store_margin;
                    if (dec_q == D_TIE) tie_flag <= 1'b1;
                    if (dec_q == D_TMO) tmo_flag <= 1'b1;
                    if (pair_idx != LAST_IDX) pair_idx <= pair_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Margin is live during the decision cycle and held afterwards.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        pair_valid = (state_q == S_STORE);
        margin     = pair_valid ? store_margin : margin_q;
    end

endmodule

// File: tb/tb_ro_race_arbiter.sv
// Randomised bench for ro_race_arbiter against a per-pair race model.
module tb_ro_race_arbiter;

    localparam int CNT_W = 4;
    localparam int NP    = 2;
    localparam int TMO   = 40;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [NP-1:0]    edge_a, edge_b;
    logic             busy, done, pair_valid, tie_flag, tmo_flag;
    logic [NP-1:0]    response;
    logic [0:0]       pair_idx;
    logic [CNT_W-1:0] margin;

    int checks = 0;
    int errors = 0;

    bit a_pat [NP][TMO];
    bit b_pat [NP][TMO];
    int exp_k [NP];
    int exp_margin [NP];
    bit exp_bit [NP];
    bit exp_tie [NP];
    bit exp_tmo [NP];

    ro_race_arbiter #(
        .CNT_W   (CNT_W),
        .N_PAIRS (NP),
        .TMO_W   (16),
        .TIMEOUT (16'd40)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .edge_a     (edge_a),
        .edge_b     (edge_b),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .pair_valid (pair_valid),
        .pair_idx   (pair_idx),
        .margin     (margin),
        .tie_flag   (tie_flag),
        .tmo_flag   (tmo_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Race each pair as the rules describe: counts climb until one reaches MAX
    // (the extra cycle to notice it drops any edges) or the timeout cycle ends.
    task automatic model_run();
        for (int p = 0; p < NP; p++) begin
            int  ca, cb;
            bit  sa, sb;
            ca = 0;
            cb = 0;
            for (int j = 0; j < TMO; j++) begin
                sa = (ca == MAX);
                sb = (cb == MAX);
                if (!sa && !sb) begin
                    ca += int'(a_pat[p][j]);
                    cb += int'(b_pat[p][j]);
                end
                if (sa || sb || j == TMO - 1) begin
                    exp_k[p]   = j + 1;
                    exp_tie[p] = sa && sb;
                    exp_tmo[p] = !sa && !sb;
                    if (sa && sb)      begin exp_bit[p] = 0;         exp_margin[p] = MAX; end
                    else if (sa)       begin exp_bit[p] = 1;         exp_margin[p] = cb;  end
                    else if (sb)       begin exp_bit[p] = 0;         exp_margin[p] = ca;  end
                    else               begin exp_bit[p] = (ca > cb); exp_margin[p] = 0;   end
                    break;
                end
            end
        end
    endtask

    task automatic noise();
        edge_a = NP'($urandom);
        edge_b = NP'($urandom);
    endtask

    // Entered #1 after a clock edge with the DUT in IDLE; leaves it back in IDLE.
    task automatic do_run(input bit hold);
        logic [NP-1:0] exp_resp;
        bit            any_tie, any_tmo;
        model_run();
        exp_resp = '0;
        any_tie  = 0;
        any_tmo  = 0;
        for (int p = 0; p < NP; p++) begin
            exp_resp[p] = exp_bit[p];
            any_tie |= exp_tie[p];
            any_tmo |= exp_tmo[p];
        end
        start = 1'b1;
        noise();
        @(posedge clk); #1;
        check_eq("accept_resp_clr", response, 0);
        check_eq("accept_tie_clr", tie_flag, 0);
        check_eq("accept_tmo_clr", tmo_flag, 0);
        for (int p = 0; p < NP; p++) begin
            check_eq("clear_busy", busy, 1);
            check_eq("clear_pv", pair_valid, 0);
            check_eq("clear_idx", pair_idx, p);
            start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            noise();
            for (int j = 0; j < exp_k[p]; j++) begin
                @(posedge clk); #1;
                check_eq("count_pv", pair_valid, 0);
                check_eq("count_done", done, 0);
                check_eq("count_idx", pair_idx, p);
                noise();
                edge_a[p] = a_pat[p][j];
                edge_b[p] = b_pat[p][j];
                if (!hold) start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            check_eq("store_pv", pair_valid, 1);
            check_eq("store_margin", margin, exp_margin[p]);
            check_eq("store_idx", pair_idx, p);
            check_eq("store_done", done, 0);
            noise();
            @(posedge clk); #1;
        end
        check_eq("done_pulse", done, 1);
        check_eq("done_busy", busy, 1);
        check_eq("done_resp", response, exp_resp);
        check_eq("done_tie", tie_flag, any_tie);
        check_eq("done_tmo", tmo_flag, any_tmo);
        check_eq("done_margin", margin, exp_margin[NP-1]);
        start = hold;
        noise();
        @(posedge clk); #1;
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_resp", response, exp_resp);
        check_eq("idle_margin", margin, exp_margin[NP-1]);
        check_eq("idle_tie", tie_flag, any_tie);
        check_eq("idle_idx", pair_idx, NP - 1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pv"}, pair_valid, 0);
        check_eq({tag, "_resp"}, response, 0);
        check_eq({tag, "_idx"}, pair_idx, 0);
        check_eq({tag, "_margin"}, margin, 0);
        check_eq({tag, "_tie"}, tie_flag, 0);
        check_eq({tag, "_tmo"}, tmo_flag, 0);
    endtask

    task automatic random_patterns();
        for (int p = 0; p < NP; p++) begin
            int da, db;
            da = $urandom_range(5, 100);
            db = $urandom_range(5, 100);
            for (int j = 0; j < TMO; j++) begin
                a_pat[p][j] = ($urandom_range(1, 100) <= da);
                b_pat[p][j] = ($urandom_range(1, 100) <= db);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        edge_a = '0;
        edge_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Abort in the middle of counting pair 0
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            noise();
            @(posedge clk); #1;
        end
        check_eq("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("abort");
        for (int c = 0; c < 30; c++) begin
            noise();
            @(posedge clk); #1;
            check_eq("abort_no_done", done, 0);
            check_eq("abort_idle", busy, 0);
        end

        // Pair 0: A every cycle, B every 2nd; pair 1: B every cycle, A every 3rd
        for (int j = 0; j < TMO; j++) begin
            a_pat[0][j] = 1;
            b_pat[0][j] = ((j + 1) % 2 == 0);
            a_pat[1][j] = ((j + 1) % 3 == 0);
            b_pat[1][j] = 1;
        end
        do_run(1'b0);

        // Tie on pair 0, timeout on pair 1, with start held across the run
        for (int j = 0; j < TMO; j++) begin
            a_pat[0][j] = 1;
            b_pat[0][j] = 1;
            a_pat[1][j] = ((j + 1) % 4 == 0);
            b_pat[1][j] = ((j + 1) % 5 == 0);
        end
        do_run(1'b1);

        for (int r = 0; r < 8; r++) begin
            random_patterns();
            do_run(r == 3);
        end

        start = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
